fp_special_case_stage: RTL

// Parametrised, pipelined special-operand stage for the FP add/sub datapath. Handles any IEEE-754 binary format.

---
 rtl/fp_special_case_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fp_special_case_stage.sv
`default_nettype none
// ============================================================================
// fp_special_case_stage : registered special-operand stage for FP add/sub
// Revision: 1.0
// ============================================================================
module fp_special_case_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [EXP_W+MANT_W:0]   i_float_A,
    input  logic [EXP_W+MANT_W:0]   i_float_B,
    input  logic                    i_sub_mode,
    input  logic [2:0]              i_rm,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_special,
    output logic [EXP_W+MANT_W:0]   o_result,
    output logic                    o_NaN,
    output logic                    o_overflow,
    output logic                    o_zero,
    output logic                    o_invalid,
    input  logic                    i_flags_clr,
    output logic [1:0]              o_flags_sticky,
    output logic [CNT_W-1:0]        o_special_cnt
);

    localparam int         W        = 1 + EXP_W + MANT_W;
    localparam logic [2:0] c_RM_RDN = 3'b010;

    logic              w_sa, w_sb_eff;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MANT_W-1:0] w_ma, w_mb;
    logic              w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic              w_snan_a, w_snan_b, w_zero_a, w_zero_b;
    logic              w_inf_inf, w_nan, w_ovf, w_zero, w_invalid;
    logic              w_ovf_sign, w_zero_sign;
    logic [W-1:0]      w_result;
    logic              w_accept, w_xfer;
    logic [1:0]        w_flags_next;

    logic              r_valid;
    logic [W-1:0]      r_result;
    logic              r_nan, r_ovf, r_zero, r_invalid;
    logic [1:0]        r_flags;
    logic [CNT_W-1:0]  r_cnt;

    assign w_sa     = i_float_A[W-1];
    assign w_ea     = i_float_A[W-2 -: EXP_W];
    assign w_ma     = i_float_A[MANT_W-1:0];
    // B's sign as seen by the adder after the subtract flip
    assign w_sb_eff = i_float_B[W-1] ^ i_sub_mode;
    assign w_eb     = i_float_B[W-2 -: EXP_W];
    assign w_mb     = i_float_B[MANT_W-1:0];

    assign w_inf_a  = &w_ea;
    assign w_inf_b  = &w_eb;
    assign w_nan_a  = w_inf_a & (|w_ma);
    assign w_nan_b  = w_inf_b & (|w_mb);
    assign w_snan_a = w_nan_a & ~w_ma[MANT_W-1];
    assign w_snan_b = w_nan_b & ~w_mb[MANT_W-1];
    assign w_zero_a = ~(|w_ea) & ~(|w_ma);
    assign w_zero_b = ~(|w_eb) & ~(|w_mb);

    assign w_inf_inf   = w_inf_a & w_inf_b & ~w_nan_a & ~w_nan_b & (w_sa ^ w_sb_eff);
    assign w_nan       = w_nan_a | w_nan_b | w_inf_inf;
    assign w_ovf       = ~w_nan & (w_inf_a | w_inf_b);
    assign w_zero      = ~w_nan & ~w_ovf & w_zero_a & w_zero_b;
    assign w_invalid   = w_snan_a | w_snan_b | w_inf_inf;
    assign w_ovf_sign  = w_inf_a ? w_sa : w_sb_eff;
    // Exact cancellation of opposite zeros is -0 only when rounding down
    assign w_zero_sign = (w_sa == w_sb_eff) ? w_sa : (i_rm == c_RM_RDN);

    always_comb begin
        w_result = '0;
        if (w_nan) begin
            w_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
        end else if (w_ovf) begin
            w_result = {w_ovf_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (w_zero) begin
            w_result = {w_zero_sign, {(W-1){1'b0}}};
        end
    end

    assign o_ready  = ~r_valid | i_ready;
    assign w_accept = i_valid & o_ready;
    assign w_xfer   = r_valid & i_ready;

    assign w_flags_next = (i_flags_clr ? 2'b00 : r_flags)
                        | (w_xfer ? {r_invalid, r_ovf} : 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_nan     <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_invalid <= 1'b0;
            r_flags   <= 2'b00;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_result  <= w_result;
                r_nan     <= w_nan;
                r_ovf     <= w_ovf;
                r_zero    <= w_zero;
                r_invalid <= w_invalid;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            r_flags <= w_flags_next;
            if (w_xfer && o_special && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_valid        = r_valid;
    assign o_result       = r_result;
    assign o_NaN          = r_nan;
    assign o_overflow     = r_ovf;
    assign o_zero         = r_zero;
    assign o_invalid      = r_invalid;
    assign o_special      = r_nan | r_ovf | r_zero;
    assign o_flags_sticky = r_flags;
    assign o_special_cnt  = r_cnt;

endmodule
`default_nettype wire
